// File: rtl/norz_icall_pkg.sv
// Shared types and constants for the conditional CALL cc,nn sequencer:
// FSM state encoding, condition indices and flag-register bit positions.
package norz_icall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_LO   = 3'd1,
    ST_RD_HI   = 3'd2,
    ST_EVAL    = 3'd3,
    ST_PUSH_HI = 3'd4,
    ST_PUSH_LO = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  localparam logic [2:0] COND_NZ = 3'd0;
  localparam logic [2:0] COND_Z  = 3'd1;
  localparam logic [2:0] COND_NC = 3'd2;
  localparam logic [2:0] COND_C  = 3'd3;
  localparam logic [2:0] COND_PO = 3'd4;
  localparam logic [2:0] COND_PE = 3'd5;
  localparam logic [2:0] COND_P  = 3'd6;
  localparam logic [2:0] COND_M  = 3'd7;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  // Only meaningful for a one-hot input; the caller qualifies with $onehot.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/icall_cond_eval.sv
// Combinational cc-condition test: selects one of the eight CALL conditions
// by index k and evaluates it against the current flag register.
module icall_cond_eval
  import norz_icall_pkg::*;
(
  input  logic [2:0] k,
  input  logic [7:0] flags,
  output logic       taken
);

  // H, N and the undefined bits never take part in a CALL condition.
  logic unused_flags;
  assign unused_flags = ^{flags[FLAG_H], flags[FLAG_N], flags[5], flags[3]};

  always_comb begin
    taken = 1'b0;
    case (k)
      COND_NZ: taken = !flags[FLAG_Z];
      COND_Z:  taken =  flags[FLAG_Z];
      COND_NC: taken = !flags[FLAG_C];
      COND_C:  taken =  flags[FLAG_C];
      COND_PO: taken = !flags[FLAG_PV];
      COND_PE: taken =  flags[FLAG_PV];
      COND_P:  taken = !flags[FLAG_S];
      COND_M:  taken =  flags[FLAG_S];
    endcase
  end

endmodule

// File: rtl/icall_ccnn_sequencer.sv
// Conditional CALL cc,nn sequencer: fetches nn, tests cc, pushes the return address.
// Build macro ICALL_TAKEN_COUNT_EN adds a saturating 16-bit TakenCount output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a one-hot start; rejects multi-hot starts
// RD_LO      | bus read of nn[7:0] at latched PC
// RD_HI      | bus read of nn[15:8] at PC+1
// EVAL       | test condition k against Flags, no bus activity
// PUSH_HI    | bus write of (PC+2)[15:8] to SP-1
// PUSH_LO    | bus write of (PC+2)[7:0] to SP-2
// FINISH     | one-cycle PC/SP load and Done pulse
module icall_ccnn_sequencer
  import norz_icall_pkg::*;
(
  input  logic        clock,
  input  logic        notReset,
  input  logic [7:0]  P2_Set_ICALLccnn,
  input  logic [7:0]  Flags,
  input  logic [15:0] PC,
  input  logic [15:0] SP,
  output logic        MemReq,
  output logic        MemWr,
  output logic [15:0] MemAddr,
  output logic [7:0]  MemWrData,
  input  logic [7:0]  MemRdData,
  input  logic        MemReady,
  output logic        PC_Load,
  output logic [15:0] PC_Next,
  output logic        SP_Load,
  output logic [15:0] SP_Next,
  output logic        Busy,
  output logic        Done,
`ifdef ICALL_TAKEN_COUNT_EN
  output logic [15:0] TakenCount,
`endif
  output logic        BadStart
);

  state_e      state_q, state_d;
  logic [2:0]  k_q;
  logic [15:0] pc_q;
  logic [15:0] sp_q;
  logic [15:0] nn_q;
  logic        taken_q;
  logic        bad_start_q;

  logic        cond_taken;
  logic        start_onehot;
  logic        start_multi;
  logic        start_any;
  logic [15:0] ret_addr;

  assign start_onehot = $onehot(P2_Set_ICALLccnn);
  assign start_multi  = ($countones(P2_Set_ICALLccnn) > 1);
  assign start_any    = |P2_Set_ICALLccnn;
  assign ret_addr     = pc_q + 16'd2;

  icall_cond_eval u_cond_eval (
    .k     (k_q),
    .flags (Flags),
    .taken (cond_taken)
  );

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_onehot) state_d = ST_RD_LO;
      ST_RD_LO:   if (MemReady) state_d = ST_RD_HI;
      ST_RD_HI:   if (MemReady) state_d = ST_EVAL;
      ST_EVAL:    state_d = cond_taken ? ST_PUSH_HI : ST_FINISH;
      ST_PUSH_HI: if (MemReady) state_d = ST_PUSH_LO;
      ST_PUSH_LO: if (MemReady) state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    MemReq    = 1'b0;
    MemWr     = 1'b0;
    MemAddr   = 16'h0000;
    MemWrData = 8'h00;
    PC_Load   = 1'b0;
    PC_Next   = 16'h0000;
    SP_Load   = 1'b0;
    SP_Next   = 16'h0000;
    Done      = 1'b0;
    case (state_q)
      ST_RD_LO: begin
        MemReq  = 1'b1;
        MemAddr = pc_q;
      end
      ST_RD_HI: begin
        MemReq  = 1'b1;
        MemAddr = pc_q + 16'd1;
      end
      ST_PUSH_HI: begin
        MemReq    = 1'b1;
        MemWr     = 1'b1;
        MemAddr   = sp_q - 16'd1;
        MemWrData = ret_addr[15:8];
      end
      ST_PUSH_LO: begin
        MemReq    = 1'b1;
        MemWr     = 1'b1;
        MemAddr   = sp_q - 16'd2;
        MemWrData = ret_addr[7:0];
      end
      ST_FINISH: begin
        PC_Load = 1'b1;
        Done    = 1'b1;
        PC_Next = taken_q ? nn_q : ret_addr;
        SP_Load = taken_q;
        SP_Next = taken_q ? (sp_q - 16'd2) : sp_q;
      end
      default: ;
    endcase
  end

  assign Busy     = (state_q != ST_IDLE);
  assign BadStart = bad_start_q;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      k_q     <= '0;
      pc_q    <= '0;
      sp_q    <= '0;
      nn_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_onehot) begin
        k_q     <= onehot_to_idx(P2_Set_ICALLccnn);
        pc_q    <= PC;
        sp_q    <= SP;
        taken_q <= 1'b0;
      end
      if (state_q == ST_RD_LO && MemReady) nn_q[7:0]  <= MemRdData;
      if (state_q == ST_RD_HI && MemReady) nn_q[15:8] <= MemRdData;
      if (state_q == ST_EVAL) taken_q <= cond_taken;
    end
  end

  // A start while busy is dropped; in IDLE only a multi-hot start is flagged.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      bad_start_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      bad_start_q <= start_multi;
    end else begin
      bad_start_q <= start_any;
    end
  end

`ifdef ICALL_TAKEN_COUNT_EN
  logic [15:0] taken_count_q;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      taken_count_q <= 16'h0000;
    end else if (state_q == ST_FINISH && taken_q && taken_count_q != 16'hFFFF) begin
      taken_count_q <= taken_count_q + 16'd1;
    end
  end

  assign TakenCount = taken_count_q;
`endif

endmodule
